keypad_entry: RTL

- Consumes the 4x4 keypad scanner's raw row lines and its held decoded key code, and turns them into one clean event per physical key press.
- Qualifies each press with a release hold-off and a settle timer, then acts on the captured key:
  - digits 0-9 are shifted into a multi-digit BCD guess;
  - key F clears the entry;
  - key E submits the entry.
- Feeds the game/compare logic with a one-cycle guess strobe.

---
 rtl/keypad_entry.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: turns raw keypad row activity plus the scanner's held key code
// into one clean key event per press, builds a multi-digit BCD entry and
// submits it as a guess.
//   clk, rst        : clock, synchronous active-high reset
//   row[3:0]        : raw active-low row lines (4'b1111 = nothing pressed)
//   key_code[3:0]   : decoded key from the scanner, held between scans
//   key_strobe      : one-cycle pulse per accepted press
//   key_value[3:0]  : key captured at the last key_strobe
//   entry_bcd       : digits entered so far, newest in the low nibble
//   digit_count     : number of valid digits in entry_bcd
//   guess_bcd       : last submitted entry
//   guess_valid     : one-cycle pulse when guess_bcd updates
module keypad_entry #(
    parameter int unsigned RELEASE_CYCLES = 500000,
    parameter int unsigned SETTLE_CYCLES  = 450000,
    parameter int unsigned NUM_DIGITS     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        row,
    input  logic [3:0]                        key_code,
    output logic                              key_strobe,
    output logic [3:0]                        key_value,
    output logic [4*NUM_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic [4*NUM_DIGITS-1:0]           guess_bcd,
    output logic                              guess_valid
);

    localparam int unsigned ENTRY_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int unsigned HOLD_W  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam int unsigned SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SETTLE       = 2'd1,
        CAPTURE      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                key_strobe_q, key_strobe_d;
    logic [3:0]          key_value_q, key_value_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENTRY_W-1:0]  guess_q, guess_d;
    logic                guess_valid_q, guess_valid_d;
    logic                key_down_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            settle_q      <= '0;
            key_strobe_q  <= 1'b0;
            key_value_q   <= '0;
            entry_q       <= '0;
            count_q       <= '0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            settle_q      <= settle_d;
            key_strobe_q  <= key_strobe_d;
            key_value_q   <= key_value_d;
            entry_q       <= entry_d;
            count_q       <= count_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
        end
    end

    // Release hold-off: bridges the gaps while the scanner visits other columns
    always_comb begin
        hold_d = hold_q;
        if (row != 4'b1111) begin
            hold_d = HOLD_W'(RELEASE_CYCLES - 1);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        key_down_c = (row != 4'b1111) || (hold_q != '0);
    end

    // Press qualification FSM and key actions
    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        key_strobe_d  = 1'b0;
        guess_valid_d = 1'b0;
        key_value_d   = key_value_q;
        entry_d       = entry_q;
        count_d       = count_q;
        guess_d       = guess_q;

        case (state_q)
            IDLE: begin
                if (key_down_c) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!key_down_c) begin
                    state_d = IDLE;
                end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            CAPTURE: begin
                key_value_d  = key_code;
                key_strobe_d = 1'b1;
                state_d      = WAIT_RELEASE;
                if (key_code <= 4'h9) begin
                    // Digits beyond capacity are dropped; the strobe still fires
                    if (count_q < CNT_W'(NUM_DIGITS)) begin
                        entry_d = ENTRY_W'({entry_q, key_code});
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (key_code == 4'hF) begin
                    entry_d = '0;
                    count_d = '0;
                end else if (key_code == 4'hE) begin
                    if (count_q != '0) begin
                        guess_d       = entry_q;
                        guess_valid_d = 1'b1;
                        entry_d       = '0;
                        count_d       = '0;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!key_down_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_strobe  = key_strobe_q;
    assign key_value   = key_value_q;
    assign entry_bcd   = entry_q;
    assign digit_count = count_q;
    assign guess_bcd   = guess_q;
    assign guess_valid = guess_valid_q;

endmodule
